// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg
//   Shared definitions for the multiply/divide unit scheduler:
//     - mdu_op_t   : MDU opcode carried down the pipe with the E-stage instruction
//     - mdu_state_t: scheduler FSM states
//     - mdu_res_t  : {hi, lo} result pair
//     - is_mul / is_div / is_signed_op : opcode classification helpers
// -----------------------------------------------------------------------------
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MFHI  = 3'd4,
        OP_MFLO  = 3'd5,
        OP_MTHI  = 3'd6,
        OP_MTLO  = 3'd7
    } mdu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } mdu_state_t;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } mdu_res_t;

    function automatic logic is_mul(input mdu_op_t op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

    function automatic logic is_div(input mdu_op_t op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_signed_op(input mdu_op_t op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/mdu_ctrl.sv
// -----------------------------------------------------------------------------
// mdu_ctrl
//   Multi-cycle scheduler for the multiply/divide unit in the E stage. Computes
//   the product or quotient/remainder on the accepting cycle into staging
//   registers, holds busy for a fixed number of cycles, then commits the
//   staged pair into the architectural HI/LO registers.
//
// Parameters
//   MULT_CYCLES  busy cycles for MULT/MULTU (1..15)
//   DIV_CYCLES   busy cycles for DIV/DIVU   (1..15)
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-low reset
//   Req       in   exception/interrupt entry; flushes the E-stage instruction
//   op_valid  in   E-stage instruction is an MDU op
//   op        in   MDU opcode
//   A, B      in   forwarded rs / rt operands
//   busy      out  multi-cycle operation in flight
//   stall     out  hold F/D/E, bubble into M
//   rd        out  MFHI/MFLO read data (0 for every other op)
//   HI, LO    out  architectural HI/LO
// -----------------------------------------------------------------------------
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic        op_valid,
    input  mdu_op_t     op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        stall,
    output logic [31:0] rd,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [3:0] MUL_LOAD = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES - 1);

    mdu_state_t  state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic [31:0] hi_nxt, lo_nxt;
    logic        div_zero;

    logic        accept;
    logic        stage_load;
    logic        commit;
    logic        write_hi;
    logic        write_lo;
    mdu_res_t    stage_val;

    // -------------------------------------------------------------------------
    // Handshake. Req flushes the E-stage instruction, so it must never start
    // MDU work; stall ignores Req because Req wins in the pipeline registers.
    // -------------------------------------------------------------------------
    assign busy   = (state != ST_IDLE);
    assign accept = op_valid && !busy && !Req;
    assign stall  = op_valid && busy;

    assign write_hi = accept && (op == OP_MTHI);
    assign write_lo = accept && (op == OP_MTLO);

    // -------------------------------------------------------------------------
    // Multiply: extend both operands to 64 bits (sign- or zero-extend by op).
    // The low 64 bits of a 64x64 product are the same whether the operands are
    // treated as signed or unsigned, so one unsigned multiplier serves both.
    // -------------------------------------------------------------------------
    logic        sign_op;
    logic [63:0] a_ext, b_ext, prod;

    assign sign_op = is_signed_op(op);
    assign a_ext   = {{32{sign_op & A[31]}}, A};
    assign b_ext   = {{32{sign_op & B[31]}}, B};
    assign prod    = a_ext * b_ext;

    // -------------------------------------------------------------------------
    // Divide: work on magnitudes, then fix signs. Quotient truncates toward
    // zero; remainder takes the sign of A. 0x80000000 has magnitude 0x80000000
    // as an unsigned value, so 0x80000000 / -1 falls out as 0x80000000 with a
    // zero remainder. A zero divisor is replaced by 1 only to keep the divider
    // well defined; that result is flagged and never committed.
    // -------------------------------------------------------------------------
    logic        a_neg, b_neg, b_zero;
    logic [31:0] a_mag, b_mag, b_safe;
    logic [31:0] q_mag, r_mag;
    logic [31:0] quo, rem;

    assign a_neg  = sign_op & A[31];
    assign b_neg  = sign_op & B[31];
    assign b_zero = (B == 32'd0);
    assign a_mag  = a_neg ? (~A + 32'd1) : A;
    assign b_mag  = b_neg ? (~B + 32'd1) : B;
    assign b_safe = b_zero ? 32'd1 : b_mag;
    assign q_mag  = a_mag / b_safe;
    assign r_mag  = a_mag % b_safe;
    assign quo    = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    assign rem    = a_neg ? (~r_mag + 32'd1) : r_mag;

    always_comb begin
        if (is_div(op)) begin
            stage_val.hi = rem;
            stage_val.lo = quo;
        end else begin
            stage_val.hi = prod[63:32];
            stage_val.lo = prod[31:0];
        end
    end

    // -------------------------------------------------------------------------
    // Next-state / counter logic.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned (which would infer a latch).
        state_next = state;
        cnt_next   = cnt;
        stage_load = 1'b0;
        commit     = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (accept && is_mul(op)) begin
                    state_next = ST_MUL;
                    cnt_next   = MUL_LOAD;
                    stage_load = 1'b1;
                end else if (accept && is_div(op)) begin
                    state_next = ST_DIV;
                    cnt_next   = DIV_LOAD;
                    stage_load = 1'b1;
                end
            end
            ST_MUL, ST_DIV: begin
                // Req is deliberately ignored here: the op already left E.
                if (cnt == 4'd0) begin
                    state_next = ST_IDLE;
                    commit     = !div_zero;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State, counter, staging and architectural registers. Reset aborts any
    // in-flight operation; the staged result is wiped so nothing can commit.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            cnt      <= 4'd0;
            hi_nxt   <= 32'd0;
            lo_nxt   <= 32'd0;
            div_zero <= 1'b0;
            HI       <= 32'd0;
            LO       <= 32'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state <= state_next;
            cnt   <= cnt_next;

            if (stage_load) begin
                hi_nxt   <= stage_val.hi;
                lo_nxt   <= stage_val.lo;
                div_zero <= is_div(op) && b_zero;
            end

            // commit only happens while busy and MTHI/MTLO only while idle,
            // so the two write sources never collide.
            if (commit) begin
                HI <= hi_nxt;
                LO <= lo_nxt;
            end else begin
                if (write_hi) HI <= A;
                if (write_lo) LO <= A;
            end
        end
    end

    // -------------------------------------------------------------------------
    // MFHI/MFLO read port.
    // -------------------------------------------------------------------------
    always_comb begin
        rd = 32'd0;
        if (op_valid) begin
            if (op == OP_MFHI) rd = HI;
            else if (op == OP_MFLO) rd = LO;
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mdu_ctrl
//   Self-checking bench for mdu_ctrl: a table of directed operations with
//   hand-computed HI/LO/rd/busy-length values, followed by hand-written
//   sequences for stalls, Req handling and reset during a divide.
// -----------------------------------------------------------------------------
module tb_mdu_ctrl;
    import mdu_pkg::*;

    logic        clk;
    logic        reset;
    logic        Req;
    logic        op_valid;
    mdu_op_t     op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        stall;
    logic [31:0] rd;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_checks = 0;
    int n_fail   = 0;

    mdu_ctrl #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .Req     (Req),
        .op_valid(op_valid),
        .op      (op),
        .A       (A),
        .B       (B),
        .busy    (busy),
        .stall   (stall),
        .rd      (rd),
        .HI      (HI),
        .LO      (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        mdu_op_t     op;
        logic [31:0] a;
        logic [31:0] b;
        int          cycles;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] rd;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs[NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Counts cycles while busy, sampled 1 time unit after each falling edge.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 20) begin
            n++;
            @(negedge clk);
            #1;
        end
    endtask

    task automatic apply_vec(input vec_t v);
        int n;
        @(negedge clk);
        // NOTE: inputs are driven with blocking assignments on the falling
        // edge, well away from the sampling rising edge.
        op_valid = 1'b1;
        op       = v.op;
        A        = v.a;
        B        = v.b;
        #1;
        check({v.name, "_stall"}, {31'd0, stall}, 32'd0);
        check({v.name, "_rd"}, rd, v.rd);
        @(negedge clk);
        op_valid = 1'b0;
        #1;
        wait_idle(n);
        check({v.name, "_cycles"}, n, v.cycles);
        check({v.name, "_hi"}, HI, v.hi);
        check({v.name, "_lo"}, LO, v.lo);
    endtask

    initial begin
        int n;

        // name, op, A, B, busy cycles, HI, LO, rd   (HI/LO carry over)
        vecs[0]  = '{"mult_neg",    OP_MULT,  32'hFFFF_FFFF, 32'd2,         5,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd0};
        vecs[1]  = '{"multu",       OP_MULTU, 32'hFFFF_FFFF, 32'd2,         5,  32'h0000_0001, 32'hFFFF_FFFE, 32'd0};
        vecs[2]  = '{"div_neg",     OP_DIV,   32'hFFFF_FFF9, 32'd2,         10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd0};
        vecs[3]  = '{"divu_zero",   OP_DIVU,  32'd7,         32'd0,         10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd0};
        vecs[4]  = '{"mfhi",        OP_MFHI,  32'd0,         32'd0,         0,  32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
        vecs[5]  = '{"mflo",        OP_MFLO,  32'd0,         32'd0,         0,  32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFD};
        vecs[6]  = '{"div_ovf",     OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000, 32'd0};
        vecs[7]  = '{"div_mixed",   OP_DIV,   32'd7,         32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD, 32'd0};
        vecs[8]  = '{"divu",        OP_DIVU,  32'd100,       32'd7,         10, 32'h0000_0002, 32'h0000_000E, 32'd0};
        vecs[9]  = '{"mult_min",    OP_MULT,  32'h8000_0000, 32'h8000_0000, 5,  32'h4000_0000, 32'h0000_0000, 32'd0};
        vecs[10] = '{"multu_carry", OP_MULTU, 32'h0001_0000, 32'h0001_0000, 5,  32'h0000_0001, 32'h0000_0000, 32'd0};
        vecs[11] = '{"mthi",        OP_MTHI,  32'h0000_1234, 32'd0,         0,  32'h0000_1234, 32'h0000_0000, 32'd0};
        vecs[12] = '{"mtlo",        OP_MTLO,  32'h0000_5678, 32'd0,         0,  32'h0000_1234, 32'h0000_5678, 32'd0};
        vecs[13] = '{"div_zero_s",  OP_DIV,   32'd5,         32'd0,         10, 32'h0000_1234, 32'h0000_5678, 32'd0};
        vecs[14] = '{"mult_small",  OP_MULT,  32'hFFFF_FFFD, 32'd7,         5,  32'hFFFF_FFFF, 32'hFFFF_FFEB, 32'd0};

        reset    = 1'b0;
        Req      = 1'b0;
        op_valid = 1'b0;
        op       = OP_MULT;
        A        = 32'd0;
        B        = 32'd0;

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy",  {31'd0, busy},  32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_rd",    rd, 32'd0);
        check("rst_hi",    HI, 32'd0);
        check("rst_lo",    LO, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // ---------------- table-driven operations ----------------
        for (int i = 0; i < NVEC; i++) apply_vec(vecs[i]);

        // ---------------- MULT 3x4 then MFLO: 5 stall cycles, rd=12 ----------------
        @(negedge clk);
        op_valid = 1'b1;
        op = OP_MULT; A = 32'd3; B = 32'd4;
        #1;
        check("mf_start_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        op = OP_MFLO; A = 32'd0; B = 32'd0;
        #1;
        n = 0;
        while (stall && n < 20) begin
            n++;
            @(negedge clk);
            #1;
        end
        check("mf_stall_cycles", n, 32'd5);
        check("mf_rd", rd, 32'd12);
        check("mf_hi", HI, 32'd0);
        @(negedge clk);
        op_valid = 1'b0;

        // ---------------- Req blocks acceptance ----------------
        @(negedge clk);
        op_valid = 1'b1; Req = 1'b1;
        op = OP_MULT; A = 32'd5; B = 32'd5;
        #1;
        check("req_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        op_valid = 1'b0; Req = 1'b0;
        #1;
        check("req_busy", {31'd0, busy}, 32'd0);
        repeat (6) @(negedge clk);
        #1;
        check("req_lo", LO, 32'd12);
        check("req_hi", HI, 32'd0);

        // ---------------- Req during busy does not cancel ----------------
        @(negedge clk);
        op_valid = 1'b1;
        op = OP_MULT; A = 32'd6; B = 32'd7;
        @(negedge clk);
        op_valid = 1'b0; Req = 1'b1;
        #1;
        check("reqbusy_busy", {31'd0, busy}, 32'd1);
        wait_idle(n);
        Req = 1'b0;
        check("reqbusy_cycles", n, 32'd5);
        check("reqbusy_lo", LO, 32'd42);
        check("reqbusy_hi", HI, 32'd0);

        // ---------------- non-MDU op while busy, MDU op stalls ----------------
        @(negedge clk);
        op_valid = 1'b1;
        op = OP_DIVU; A = 32'd9; B = 32'd2;
        @(negedge clk);
        op_valid = 1'b0;
        #1;
        check("nonmdu_busy",  {31'd0, busy},  32'd1);
        check("nonmdu_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        op_valid = 1'b1; op = OP_MTHI; A = 32'hDEAD_BEEF;
        #1;
        check("mdu_stall", {31'd0, stall}, 32'd1);
        @(negedge clk);
        op_valid = 1'b0;
        #1;
        wait_idle(n);
        check("stalled_hi", HI, 32'd1);
        check("stalled_lo", LO, 32'd4);

        // ---------------- reset mid-DIV aborts ----------------
        @(negedge clk);
        op_valid = 1'b1;
        op = OP_DIV; A = 32'd100; B = 32'd3;
        @(negedge clk);            // cycle t+1
        op_valid = 1'b0;
        @(negedge clk);            // cycle t+2
        @(negedge clk);            // cycle t+3
        reset = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_hi", HI, 32'd0);
        check("abort_lo", LO, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        #1;
        check("abort_after_busy", {31'd0, busy}, 32'd0);
        check("abort_after_hi", HI, 32'd0);
        check("abort_after_lo", LO, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
